// File: rtl/key_matrix_scan.sv
// key_matrix_scan: 4x4 keypad row scanner with debounced press/release detection.
// Optional auto-repeat of the held key is built when KEY_REPEAT_EN is defined.
module key_matrix_scan #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 4,
    parameter int unsigned REPEAT_DELAY = 50,
    parameter int unsigned REPEAT_RATE  = 10
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CNT + 1);

    if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("key_matrix_scan: parameter below its minimum");
    end

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        cap_col_q, cap_col_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]        col_m_q, col_s_q;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q, key_held_d;

    logic              sample;
    logic [1:0]        low_col;
    logic              cap_low;
    logic [DEB_W-1:0]  deb_inc;
    logic              deb_done;

`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_armed_q, rep_armed_d;
    logic [REP_W-1:0] rep_inc;
    logic [REP_W-1:0] rep_target;
`endif

    assign sample    = (slot_q == SLOT_W'(SCAN_DIV - 1));
    assign slot_d    = sample ? '0 : slot_q + SLOT_W'(1);
    assign row       = ~(4'b0001 << idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

    always_comb begin
        low_col = 2'd3;
        if (!col_s_q[0]) begin
            low_col = 2'd0;
        end else if (!col_s_q[1]) begin
            low_col = 2'd1;
        end else if (!col_s_q[2]) begin
            low_col = 2'd2;
        end
        cap_low  = ~col_s_q[cap_col_q];
        deb_inc  = deb_cnt_q + DEB_W'(1);
        deb_done = (deb_inc == DEB_W'(DEBOUNCE_CNT));

        state_d     = state_q;
        idx_d       = idx_q;
        cap_col_d   = cap_col_q;
        deb_cnt_d   = deb_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
`ifdef KEY_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_inc     = rep_cnt_q + REP_W'(1);
        rep_target  = rep_armed_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY);
`endif

        // Every state decision is taken only at the end of a row slot.
        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (col_s_q == 4'b1111) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        cap_col_d = low_col;
                        deb_cnt_d = DEB_W'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            state_d     = PRESSED;
                            deb_cnt_d   = '0;
                            key_valid_d = 1'b1;
                            key_code_d  = {idx_q, low_col};
                            key_held_d  = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (cap_low) begin
                        deb_cnt_d = deb_inc;
                        if (deb_done) begin
                            state_d     = PRESSED;
                            deb_cnt_d   = '0;
                            key_valid_d = 1'b1;
                            key_code_d  = {idx_q, cap_col_q};
                            key_held_d  = 1'b1;
                        end
                    end else begin
                        deb_cnt_d = '0;
                        idx_d     = idx_q + 2'd1;
                        state_d   = SCAN;
                    end
                end
                PRESSED: begin
                    if (!cap_low) begin
`ifdef KEY_REPEAT_EN
                        rep_cnt_d   = '0;
                        rep_armed_d = 1'b0;
`endif
                        if (DEBOUNCE_CNT == 1) begin
                            deb_cnt_d  = '0;
                            key_held_d = 1'b0;
                            idx_d      = idx_q + 2'd1;
                            state_d    = SCAN;
                        end else begin
                            deb_cnt_d = DEB_W'(1);
                            state_d   = RELEASE;
                        end
                    end else begin
`ifdef KEY_REPEAT_EN
                        // First repeat waits REPEAT_DELAY samples, later ones REPEAT_RATE.
                        if (rep_inc == rep_target) begin
                            key_valid_d = 1'b1;
                            rep_cnt_d   = '0;
                            rep_armed_d = 1'b1;
                        end else begin
                            rep_cnt_d = rep_inc;
                        end
`endif
                    end
                end
                RELEASE: begin
                    if (!cap_low) begin
                        deb_cnt_d = deb_inc;
                        if (deb_done) begin
                            deb_cnt_d  = '0;
                            key_held_d = 1'b0;
                            idx_d      = idx_q + 2'd1;
                            state_d    = SCAN;
                        end
                    end else begin
                        deb_cnt_d = '0;
                        state_d   = PRESSED;
`ifdef KEY_REPEAT_EN
                        rep_cnt_d   = '0;
                        rep_armed_d = 1'b0;
`endif
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            slot_q      <= '0;
            idx_q       <= 2'd0;
            cap_col_q   <= 2'd0;
            deb_cnt_q   <= '0;
            col_m_q     <= 4'b1111;
            col_s_q     <= 4'b1111;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            cap_col_q   <= cap_col_d;
            deb_cnt_q   <= deb_cnt_d;
            col_m_q     <= col;
            col_s_q     <= col_m_q;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEY_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
`endif
        end
    end
endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan with a behavioural 4x4 keypad on row/col.
// SCAN_DIV=4, DEBOUNCE_CNT=3; n counts clock edges since the last reset edge.
module tb_key_matrix_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = 16'h0000;

    int n = 0;
    int checks = 0;
    int passes = 0;

    key_matrix_scan #(
        .SCAN_DIV(4),
        .DEBOUNCE_CNT(3),
        .REPEAT_DELAY(5),
        .REPEAT_RATE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .row(row),
        .col(col),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its column low while its row is driven low.
    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
    endtask

    task automatic test_reset();
        keys = 16'h0000;
        do_reset();
        checks++; if (row !== 4'b1110) $display("FAIL reset_row got %b want 1110", row); else passes++;
        checks++; if (key_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", key_valid); else passes++;
        checks++; if (key_held !== 1'b0) $display("FAIL reset_held got %b want 0", key_held); else passes++;
        checks++; if (key_code !== 4'd0) $display("FAIL reset_code got %0d want 0", key_code); else passes++;
    endtask

    task automatic test_idle();
        logic [3:0] exp_row;
        keys = 16'h0000;
        do_reset();
        while (n < 64) begin
            exp_row = ~(4'b0001 << ((n / 4) % 4));
            checks++; if (row !== exp_row) $display("FAIL idle_row n=%0d got %b want %b", n, row, exp_row); else passes++;
            checks++; if (key_valid !== 1'b0) $display("FAIL idle_valid n=%0d got %b want 0", n, key_valid); else passes++;
            tick();
        end
    endtask

    task automatic test_clean_press();
        keys = 16'h0000;
        do_reset();
        keys = 16'h0200;
        while (n < 56) begin
            checks++; if (key_valid !== (n == 20)) $display("FAIL press_valid n=%0d got %b want %b", n, key_valid, (n == 20)); else passes++;
            if (n == 12 || n == 30) begin
                checks++; if (row !== 4'b1011) $display("FAIL press_row_frozen n=%0d got %b want 1011", n, row); else passes++;
            end
            if (n == 20) begin
                checks++; if (key_code !== 4'd9) $display("FAIL press_code got %0d want 9", key_code); else passes++;
                checks++; if (key_held !== 1'b1) $display("FAIL press_held got %b want 1", key_held); else passes++;
            end
            if (n == 51) begin
                checks++; if (key_held !== 1'b1) $display("FAIL release_held_early got %b want 1", key_held); else passes++;
            end
            if (n == 52) begin
                checks++; if (key_held !== 1'b0) $display("FAIL release_held got %b want 0", key_held); else passes++;
                checks++; if (row !== 4'b0111) $display("FAIL release_row got %b want 0111", row); else passes++;
                checks++; if (key_code !== 4'd9) $display("FAIL release_code_hold got %0d want 9", key_code); else passes++;
            end
            if (n == 40) keys = 16'h0000;
            tick();
        end
    endtask

    task automatic test_bounce();
        keys = 16'h0000;
        do_reset();
        keys = 16'h0200;
        while (n < 40) begin
            checks++; if (key_valid !== 1'b0) $display("FAIL bounce_valid n=%0d got %b want 0", n, key_valid); else passes++;
            if (n == 12) begin
                checks++; if (row !== 4'b1011) $display("FAIL bounce_row_frozen got %b want 1011", row); else passes++;
            end
            if (n == 20) begin
                checks++; if (row !== 4'b0111) $display("FAIL bounce_row_resume got %b want 0111", row); else passes++;
                checks++; if (key_held !== 1'b0) $display("FAIL bounce_held got %b want 0", key_held); else passes++;
            end
            if (n == 16) keys = 16'h0000;
            tick();
        end
    endtask

    task automatic test_release_glitch();
        keys = 16'h0000;
        do_reset();
        keys = 16'h0200;
        while (n < 44) begin
            checks++; if (key_valid !== (n == 20)) $display("FAIL glitch_valid n=%0d got %b want %b", n, key_valid, (n == 20)); else passes++;
            if (n >= 20) begin
                checks++; if (key_held !== 1'b1) $display("FAIL glitch_held n=%0d got %b want 1", n, key_held); else passes++;
            end
            if (n == 36) begin
                checks++; if (row !== 4'b1011) $display("FAIL glitch_row got %b want 1011", row); else passes++;
            end
            if (n == 24) keys = 16'h0000;
            if (n == 28) keys = 16'h0200;
            tick();
        end
    endtask

    task automatic test_two_keys();
        keys = 16'h0000;
        do_reset();
        keys = 16'h0090;
        while (n < 44) begin
            checks++; if (key_valid !== (n == 16)) $display("FAIL two_valid n=%0d got %b want %b", n, key_valid, (n == 16)); else passes++;
            if (n == 10) begin
                checks++; if (row !== 4'b1101) $display("FAIL two_row_frozen got %b want 1101", row); else passes++;
            end
            if (n == 16) begin
                checks++; if (key_code !== 4'd4) $display("FAIL two_code got %0d want 4", key_code); else passes++;
                checks++; if (key_held !== 1'b1) $display("FAIL two_held got %b want 1", key_held); else passes++;
                keys = 16'h0080;
            end
            if (n == 27) begin
                checks++; if (key_held !== 1'b1) $display("FAIL two_held_early got %b want 1", key_held); else passes++;
            end
            if (n == 28) begin
                checks++; if (key_held !== 1'b0) $display("FAIL two_release_held got %b want 0", key_held); else passes++;
                checks++; if (row !== 4'b1011) $display("FAIL two_release_row got %b want 1011", row); else passes++;
            end
            if (n == 40) begin
                checks++; if (key_code !== 4'd4) $display("FAIL two_code_hold got %0d want 4", key_code); else passes++;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        keys = 16'h0000;
        do_reset();
        keys = 16'h0200;
        while (n < 51) begin
            checks++; if (key_valid !== (n == 20)) $display("FAIL mid_valid n=%0d got %b want %b", n, key_valid, (n == 20)); else passes++;
            if (n == 20) begin
                checks++; if (key_code !== 4'd9) $display("FAIL mid_code got %0d want 9", key_code); else passes++;
                keys = 16'h0000;
            end
            if (n == 32) begin
                checks++; if (row !== 4'b0111) $display("FAIL mid_scan_row got %b want 0111", row); else passes++;
                checks++; if (key_held !== 1'b0) $display("FAIL mid_scan_held got %b want 0", key_held); else passes++;
                keys = 16'h0200;
            end
            if (n == 49) begin
                checks++; if (row !== 4'b1011) $display("FAIL mid_deb_row got %b want 1011", row); else passes++;
            end
            if (n == 50) rst = 1'b1;
            tick();
        end
        checks++; if (row !== 4'b1110) $display("FAIL mid_rst_row got %b want 1110", row); else passes++;
        checks++; if (key_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", key_valid); else passes++;
        checks++; if (key_held !== 1'b0) $display("FAIL mid_rst_held got %b want 0", key_held); else passes++;
        checks++; if (key_code !== 4'd0) $display("FAIL mid_rst_code got %0d want 0", key_code); else passes++;
        rst = 1'b0;
        n = 0;
        while (n < 24) begin
            checks++; if (key_valid !== (n == 20)) $display("FAIL mid_redetect_valid n=%0d got %b want %b", n, key_valid, (n == 20)); else passes++;
            if (n == 20) begin
                checks++; if (key_code !== 4'd9) $display("FAIL mid_redetect_code got %0d want 9", key_code); else passes++;
                checks++; if (key_held !== 1'b1) $display("FAIL mid_redetect_held got %b want 1", key_held); else passes++;
            end
            tick();
        end
    endtask

    task automatic test_long_hold();
        logic exp_v;
        keys = 16'h0000;
        do_reset();
        keys = 16'h0200;
        while (n < 72) begin
`ifdef KEY_REPEAT_EN
            exp_v = (n == 20) || (n == 40) || (n == 48) || (n == 56) || (n == 64);
`else
            exp_v = (n == 20);
`endif
            checks++; if (key_valid !== exp_v) $display("FAIL hold_valid n=%0d got %b want %b", n, key_valid, exp_v); else passes++;
            if (n >= 20) begin
                checks++; if (key_code !== 4'd9) $display("FAIL hold_code n=%0d got %0d want 9", n, key_code); else passes++;
            end
            if (n == 68) keys = 16'h0000;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_two_keys();
        test_reset_mid();
        test_long_hold();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/key_matrix_scan.md
KEY_MATRIX_SCAN -- requirements
Module: key_matrix_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clock cycles per row slot, minimum 2.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4: consecutive matching samples needed to accept a press or a release, minimum 1.
REQ-003 SHALL have parameter REPEAT_DELAY, default 50: samples from first key_valid to first repeat. Used only under KEY_REPEAT_EN.
REQ-004 SHALL have parameter REPEAT_RATE, default 10: samples between repeats. Used only under KEY_REPEAT_EN.
REQ-005 Ports:
- clk  input  1  system clock; all logic on posedge clk.
- rst  input  1  synchronous, active-high reset.
- row  output  4  active-low one-hot row drive to the 4x4 keypad.
- col  input  4  active-low column sense, pulled up externally, asynchronous to clk.
- key_code  output  4  code of the accepted key, row_index*4+col_index.
- key_valid  output  1  one-cycle pulse when a key press is accepted.
- key_held  output  1  high while an accepted key is still pressed.

Function
REQ-006 SHALL synchronise col through two flops; all decisions SHALL use the synchronised value col_s.
REQ-007 SHALL run a slot counter 0..SCAN_DIV-1. The sample point SHALL be the cycle in which slot count == SCAN_DIV-1. The counter SHALL then wrap to 0.
REQ-008 SHALL drive row = ~(1<<idx) with idx 0..3. idx SHALL change only at a sample point and only in state SCAN, wrapping from 3 to 0.
REQ-009 FSM states SHALL be SCAN, DEBOUNCE, PRESSED and RELEASE. All transitions SHALL occur only at sample points.
REQ-010 SCAN, col_s == 4'b1111: advance idx and stay in SCAN.
REQ-011 SCAN, col_s != 4'b1111: capture idx and the lowest-index low column; set deb_cnt = 1; freeze row; enter DEBOUNCE. If DEBOUNCE_CNT == 1, go directly to the PRESSED action in REQ-012.
REQ-012 DEBOUNCE:
- Captured column low: increment deb_cnt.
- When deb_cnt reaches DEBOUNCE_CNT: enter PRESSED. key_valid SHALL pulse high for exactly the next cycle, with key_code updated and key_held = 1 in that same cycle.
REQ-013 DEBOUNCE, captured column high: clear deb_cnt, advance idx, return to SCAN, and assert no output.
REQ-014 PRESSED, captured column high: set deb_cnt = 1 and enter RELEASE. While it stays low: remain in PRESSED.
REQ-015 RELEASE:
- Captured column high: increment deb_cnt. On reaching DEBOUNCE_CNT, clear key_held, advance idx and enter SCAN.
- Captured column low: return to PRESSED with no new key_valid.
REQ-016 Only the captured key SHALL be evaluated from DEBOUNCE through RELEASE. Other keys pressed meanwhile SHALL be ignored until SCAN resumes.
REQ-017 key_code SHALL hold its last value until the next accepted press. key_valid SHALL never be high for two consecutive cycles.
REQ-018 Latency from the first low sample to key_valid SHALL be DEBOUNCE_CNT-1 further sample points plus 1 cycle.

Reset
REQ-019 While rst is high at posedge clk, the block SHALL set:
- state = SCAN, idx = 0, row = 4'b1110
- slot counter = 0, deb_cnt = 0, repeat counter = 0
- synchroniser flops = 4'b1111
- key_code = 0, key_valid = 0, key_held = 0
REQ-020 Reset SHALL win over any simultaneous event. A reset asserted mid-press SHALL emit no pulse. A key still held after reset SHALL be re-detected as a new press through the normal debounce.

Configuration
REQ-021 With KEY_REPEAT_EN defined, in PRESSED:
- Count sample points with the key held.
- Pulse key_valid, same key_code, after REPEAT_DELAY samples, then every REPEAT_RATE samples.
- Entering RELEASE SHALL clear the repeat counter. Returning from RELEASE to PRESSED SHALL restart the count at 0.
REQ-022 Without KEY_REPEAT_EN, there SHALL be exactly one key_valid per accepted press, and no repeat counter logic SHALL be present.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_DELAY=5, REPEAT_RATE=2)
REQ-023 Idle: col=4'b1111 for 64 cycles after reset -> row cycles 1110, 1101, 1011, 0111, each held 4 cycles; key_valid stays 0.
REQ-024 Clean press: key row 2 col 1 held steady -> row freezes at 1011; exactly one key_valid; key_code=9; key_held=1.
REQ-025 Bounce:
- col low for 2 samples, then high -> no key_valid; scanning resumes at row 0111.
- Release glitch, 1 high sample then low -> key_held stays 1 and no new pulse.
REQ-026 Two keys on row 1, cols 0 and 3 -> key_code=4. Release of col 0 for 3 samples -> key_held=0 and SCAN resumes.
REQ-027 Reset mid-operation: rst during DEBOUNCE -> row=1110 and all outputs 0 on the next cycle. Key still held -> one key_valid after 3 fresh samples.
REQ-028 KEY_REPEAT_EN, key held 12 samples after acceptance -> key_valid pulses at acceptance, at +5, at +7, at +9 and at +11 samples.
